// File: rtl/nr_pkg.sv
// Shared widths, Q8.24 constants, FSM encoding and saturating fixed-point helpers
// for the Newton-Raphson update stage.
package nr_pkg;
   localparam int DW = 32;
   localparam int FB = 24;
   localparam int AW = 66;
   localparam logic [DW-1:0] ONE = 32'h0100_0000;
   localparam logic [DW-1:0] MAX = 32'h7FFF_FFFF;
   localparam logic [DW-1:0] MIN = 32'h8000_0000;
   localparam logic [DW-1:0] TOL = 32'h0000_0100;

   typedef enum logic [2:0] {S_IDLE, S_MAC, S_SCALE, S_UPDATE, S_DONE} state_t;

   // In range only when every bit above the result's sign bit copies the sign.
   function automatic logic [DW-1:0] sat32(input logic [AW-1:0] v);
      if (!v[AW-1] && (|v[AW-2:DW-1])) return MAX;
      if (v[AW-1] && !(&v[AW-2:DW-1])) return MIN;
      return v[DW-1:0];
   endfunction

   function automatic logic [DW-1:0] q_shift(input logic [AW-1:0] v);
      return sat32($signed(v) >>> FB);
   endfunction

   // 33-bit magnitude so that -2^31 maps to 2^31 and never passes.
   function automatic logic within_tol(input logic [DW-1:0] v);
      logic [DW:0] mag;
      mag = v[DW-1] ? ({1'b0, ~v} + 33'd1) : {1'b0, v};
      return (mag <= {1'b0, TOL});
   endfunction
endpackage

// File: rtl/nr_mac.sv
// Shared signed DWxDW multiplier with a registered 64-bit product and a 66-bit accumulator.
// One-cycle product latency; acc_en_i/acc_clr_i qualify the product currently held in the register.
module nr_mac
   import nr_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [DW-1:0]     a_i,
   input  logic [DW-1:0]     b_i,
   input  logic              acc_en_i,
   input  logic              acc_clr_i,
   output logic [2*DW-1:0]   prod_o,
   output logic [AW-1:0]     acc_nxt_o
);
   logic [2*DW-1:0] prod_q, a_ext, b_ext;
   logic [AW-1:0]   acc_q, acc_d, prod_ext;

   assign a_ext    = {{DW{a_i[DW-1]}}, a_i};
   assign b_ext    = {{DW{b_i[DW-1]}}, b_i};
   assign prod_ext = {{(AW-2*DW){prod_q[2*DW-1]}}, prod_q};

   always_comb begin
      acc_d = acc_q;
      if (acc_en_i) acc_d = acc_clr_i ? prod_ext : acc_q + prod_ext;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prod_q <= '0;
         acc_q  <= '0;
      end else begin
         prod_q <= $signed(a_ext) * $signed(b_ext);
         acc_q  <= acc_d;
      end
   end

   assign prod_o    = prod_q;
   assign acc_nxt_o = acc_d;
endmodule

// File: rtl/nr_update.sv
// Newton-Raphson update X_next = X - (Aj*F)*d with convergence flag; done rises 14 clocks after accept.
// No backpressure: en is ignored while busy and results hold in DONE until the next accept.
module nr_update
   import nr_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic [DW-1:0] x,
   input  logic [DW-1:0] y,
   input  logic [DW-1:0] z,
   input  logic [DW-1:0] f0,
   input  logic [DW-1:0] f1,
   input  logic [DW-1:0] f2,
   input  logic [DW-1:0] Aj00,
   input  logic [DW-1:0] Aj01,
   input  logic [DW-1:0] Aj02,
   input  logic [DW-1:0] Aj10,
   input  logic [DW-1:0] Aj11,
   input  logic [DW-1:0] Aj12,
   input  logic [DW-1:0] Aj20,
   input  logic [DW-1:0] Aj21,
   input  logic [DW-1:0] Aj22,
   input  logic [DW-1:0] d,
   output logic          busy,
   output logic          done,
   output logic [DW-1:0] x_n,
   output logic [DW-1:0] y_n,
   output logic [DW-1:0] z_n,
   output logic [DW-1:0] dx,
   output logic [DW-1:0] dy,
   output logic [DW-1:0] dz,
   output logic          conv
);
   state_t                state_q;
   logic [3:0]            cnt_q;
   logic [1:0]            row_q, col_q, acc_row_q, sc_idx_q;
   logic                  acc_en_q, acc_clr_q, acc_last_q, sc_en_q;
   logic [8:0][DW-1:0]    aj_q;
   logic [2:0][DW-1:0]    f_q, x_q, t_q, dl_q, xn_q, dout_q, xn_d;
   logic [2:0][DW:0]      diff;
   logic [DW-1:0]         d_q, mul_a, mul_b;
   logic                  busy_q, done_q, conv_q, conv_d;
   logic [2*DW-1:0]       prod;
   logic [AW-1:0]         acc_nxt;

   nr_mac u_mac (
      .clk       (clk),
      .rst       (rst),
      .a_i       (mul_a),
      .b_i       (mul_b),
      .acc_en_i  (acc_en_q),
      .acc_clr_i (acc_clr_q),
      .prod_o    (prod),
      .acc_nxt_o (acc_nxt)
   );

   always_comb begin
      mul_a = '0;
      mul_b = '0;
      case (state_q)
         S_MAC: begin
            mul_a = aj_q[cnt_q];
            mul_b = f_q[col_q];
         end
         S_SCALE: begin
            mul_b = d_q;
            case (cnt_q[1:0])
               2'd0:    mul_a = t_q[0];
               2'd1:    mul_a = t_q[1];
               2'd2:    mul_a = t_q[2];
               default: mul_a = '0;
            endcase
         end
         default: ;
      endcase
   end

   always_comb begin
      diff   = '0;
      xn_d   = '0;
      conv_d = 1'b1;
      for (int i = 0; i < 3; i++) begin
         diff[i] = {x_q[i][DW-1], x_q[i]} - {dl_q[i][DW-1], dl_q[i]};
         xn_d[i] = sat32({{(AW-DW-1){diff[i][DW]}}, diff[i]});
         conv_d  = conv_d & within_tol(dl_q[i]);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         row_q      <= '0;
         col_q      <= '0;
         acc_row_q  <= '0;
         sc_idx_q   <= '0;
         acc_en_q   <= 1'b0;
         acc_clr_q  <= 1'b0;
         acc_last_q <= 1'b0;
         sc_en_q    <= 1'b0;
         aj_q       <= '0;
         f_q        <= '0;
         x_q        <= '0;
         d_q        <= '0;
         t_q        <= '0;
         dl_q       <= '0;
         xn_q       <= '0;
         dout_q     <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         conv_q     <= 1'b0;
      end else begin
         acc_en_q <= 1'b0;
         sc_en_q  <= 1'b0;
         // Pipeline tags trail the issued operands by one cycle, matching the product register.
         if (acc_en_q && acc_last_q) t_q[acc_row_q] <= q_shift(acc_nxt);
         if (sc_en_q) dl_q[sc_idx_q] <= q_shift({{(AW-2*DW){prod[2*DW-1]}}, prod});
         case (state_q)
            S_IDLE, S_DONE: begin
               if (en) begin
                  aj_q    <= {Aj22, Aj21, Aj20, Aj12, Aj11, Aj10, Aj02, Aj01, Aj00};
                  f_q     <= {f2, f1, f0};
                  x_q     <= {z, y, x};
                  d_q     <= d;
                  cnt_q   <= '0;
                  row_q   <= '0;
                  col_q   <= '0;
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
                  state_q <= S_MAC;
               end
            end
            S_MAC: begin
               acc_en_q   <= 1'b1;
               acc_clr_q  <= (col_q == 2'd0);
               acc_last_q <= (col_q == 2'd2);
               acc_row_q  <= row_q;
               if (col_q == 2'd2) begin
                  col_q <= '0;
                  row_q <= row_q + 2'd1;
               end else begin
                  col_q <= col_q + 2'd1;
               end
               if (cnt_q == 4'd8) begin
                  cnt_q   <= '0;
                  state_q <= S_SCALE;
               end else begin
                  cnt_q <= cnt_q + 4'd1;
               end
            end
            S_SCALE: begin
               // Three issue slots, then one slot to drain the last product into delta.
               if (cnt_q != 4'd3) begin
                  sc_en_q  <= 1'b1;
                  sc_idx_q <= cnt_q[1:0];
                  cnt_q    <= cnt_q + 4'd1;
               end else begin
                  cnt_q   <= '0;
                  state_q <= S_UPDATE;
               end
            end
            S_UPDATE: begin
               xn_q    <= xn_d;
               dout_q  <= dl_q;
               conv_q  <= conv_d;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
               state_q <= S_DONE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign conv = conv_q;
   assign x_n  = xn_q[0];
   assign y_n  = xn_q[1];
   assign z_n  = xn_q[2];
   assign dx   = dout_q[0];
   assign dy   = dout_q[1];
   assign dz   = dout_q[2];
endmodule

// File: tb/tb_nr_update.sv
// Bench for nr_update: table of hand-computed vectors, random vectors against a reference model,
// and hand-written sequences for busy re-requests and mid-operation reset.
module tb_nr_update;
   typedef logic [8:0][31:0] aj_t;
   typedef logic [2:0][31:0] v3_t;
   typedef struct {
      aj_t         aj;
      logic [31:0] d;
      v3_t         xv, fv, dl, xn;
      logic        conv;
   } vec_t;
   typedef struct {
      v3_t  dl, xn;
      logic conv;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst, en;
   logic [31:0] x, y, z, f0, f1, f2, d;
   logic [31:0] Aj00, Aj01, Aj02, Aj10, Aj11, Aj12, Aj20, Aj21, Aj22;
   logic        busy, done, conv;
   logic [31:0] x_n, y_n, z_n, dx, dy, dz;

   exp_t sb[$];
   vec_t tbl[10];
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   nr_update dut (
      .clk(clk), .rst(rst), .en(en), .x(x), .y(y), .z(z), .f0(f0), .f1(f1), .f2(f2),
      .Aj00(Aj00), .Aj01(Aj01), .Aj02(Aj02), .Aj10(Aj10), .Aj11(Aj11), .Aj12(Aj12),
      .Aj20(Aj20), .Aj21(Aj21), .Aj22(Aj22), .d(d), .busy(busy), .done(done),
      .x_n(x_n), .y_n(y_n), .z_n(z_n), .dx(dx), .dy(dy), .dz(dz), .conv(conv)
   );

   function automatic v3_t v3(input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2);
      return {a2, a1, a0};
   endfunction

   function automatic aj_t diag(input logic [31:0] v);
      aj_t r;
      r = '0;
      r[0] = v; r[4] = v; r[8] = v;
      return r;
   endfunction

   function automatic vec_t mk(input aj_t aj, input logic [31:0] dd, input v3_t xv, input v3_t fv,
                               input v3_t dl, input v3_t xn, input logic cv);
      vec_t v;
      v.aj = aj; v.d = dd; v.xv = xv; v.fv = fv; v.dl = dl; v.xn = xn; v.conv = cv;
      return v;
   endfunction

   function automatic logic [31:0] bsat(input logic signed [65:0] v);
      if (v > 66'sd2147483647) return 32'h7FFF_FFFF;
      if (v < -66'sd2147483648) return 32'h8000_0000;
      return v[31:0];
   endfunction

   function automatic void model(inout vec_t v);
      logic signed [65:0] acc, s, df;
      logic [31:0]        t;
      longint             m;
      v.conv = 1'b1;
      for (int i = 0; i < 3; i++) begin
         acc = '0;
         for (int j = 0; j < 3; j++)
            acc = acc + 66'($signed(v.aj[i*3+j])) * 66'($signed(v.fv[j]));
         t = bsat(acc >>> 24);
         s = 66'($signed(t)) * 66'($signed(v.d));
         v.dl[i] = bsat(s >>> 24);
         df = 66'($signed(v.xv[i])) - 66'($signed(v.dl[i]));
         v.xn[i] = bsat(df);
         m = longint'($signed(v.dl[i]));
         if (m < 0) m = -m;
         if (m > 256) v.conv = 1'b0;
      end
   endfunction

   function automatic logic [31:0] rnd_q();
      return $urandom_range(0, 32'h07FF_FFFF) - 32'h0400_0000;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      {Aj22, Aj21, Aj20, Aj12, Aj11, Aj10, Aj02, Aj01, Aj00} = v.aj;
      {z, y, x}    = v.xv;
      {f2, f1, f0} = v.fv;
      d = v.d;
   endtask

   task automatic scramble();
      {Aj22, Aj21, Aj20, Aj12, Aj11, Aj10} = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      {Aj02, Aj01, Aj00, x, y, z} = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      {f0, f1, f2, d} = {$urandom, $urandom, $urandom, $urandom};
   endtask

   task automatic check_out(input string tag);
      exp_t e;
      e = sb.pop_front();
      chk({tag, " dx"}, dx, e.dl[0]);
      chk({tag, " dy"}, dy, e.dl[1]);
      chk({tag, " dz"}, dz, e.dl[2]);
      chk({tag, " x_n"}, x_n, e.xn[0]);
      chk({tag, " y_n"}, y_n, e.xn[1]);
      chk({tag, " z_n"}, z_n, e.xn[2]);
      chk({tag, " conv"}, {31'b0, conv}, {31'b0, e.conv});
      chk({tag, " busy@done"}, {31'b0, busy}, 32'd0);
   endtask

   // Accepts v, optionally re-requests with alt while busy, then checks latency and results.
   task automatic run(input vec_t v, input string tag, input int en_at, input vec_t alt);
      exp_t e;
      int   cyc;
      @(negedge clk);
      drive(v);
      en = 1'b1;
      e.dl = v.dl; e.xn = v.xn; e.conv = v.conv;
      sb.push_back(e);
      @(posedge clk); #1;
      en = 1'b0;
      scramble();
      chk({tag, " busy@accept"}, {31'b0, busy}, 32'd1);
      chk({tag, " done@accept"}, {31'b0, done}, 32'd0);
      cyc = 0;
      while (!done && cyc < 40) begin
         if (cyc == en_at) begin
            drive(alt);
            en = 1'b1;
         end
         @(posedge clk); #1;
         en = 1'b0;
         cyc++;
      end
      chk({tag, " latency"}, cyc, 32'd14);
      check_out(tag);
   endtask

   initial begin
      vec_t v;
      rst = 1'b0; en = 1'b0;
      drive(mk('0, '0, '0, '0, '0, '0, 1'b0));

      tbl[0] = mk(diag(32'h0100_0000), 32'h0100_0000, v3(32'h0100_0000, 32'h0200_0000, 32'h0300_0000),
                  v3(32'h0100_0000, 32'h0200_0000, 32'h0300_0000), v3(32'h0100_0000, 32'h0200_0000, 32'h0300_0000),
                  v3(0, 0, 0), 1'b0);
      tbl[1] = mk(diag(32'h0100_0000), 32'h0100_0000, v3(32'h0100_0000, 32'h0200_0000, 32'h0300_0000),
                  v3(0, 0, 0), v3(0, 0, 0), v3(32'h0100_0000, 32'h0200_0000, 32'h0300_0000), 1'b1);
      tbl[2] = mk(diag(32'h0100_0000), 32'h0, v3(32'h0100_0000, 32'h0200_0000, 32'h0300_0000),
                  v3(32'h0100_0000, 32'h0200_0000, 32'h0300_0000), v3(0, 0, 0),
                  v3(32'h0100_0000, 32'h0200_0000, 32'h0300_0000), 1'b1);
      tbl[3] = mk(diag(32'h0200_0000), 32'h0040_0000, v3(0, 0, 0),
                  v3(32'h0100_0000, 32'hFE00_0000, 32'h0080_0000), v3(32'h0080_0000, 32'hFF00_0000, 32'h0040_0000),
                  v3(32'hFF80_0000, 32'h0100_0000, 32'hFFC0_0000), 1'b0);
      tbl[4] = mk(diag(32'h0100_0000), 32'h0100_0000, v3(32'h7F00_0000, 0, 32'h8000_0000),
                  v3(32'hFE00_0000, 0, 32'h0200_0000), v3(32'hFE00_0000, 0, 32'h0200_0000),
                  v3(32'h7FFF_FFFF, 0, 32'h8000_0000), 1'b0);
      tbl[5] = mk(diag(32'h0100_0000), 32'h0100_0000, v3(0, 0, 0), v3(32'h100, 32'hFFFF_FF00, 0),
                  v3(32'h100, 32'hFFFF_FF00, 0), v3(32'hFFFF_FF00, 32'h100, 0), 1'b1);
      tbl[6] = mk(diag(32'h0100_0000), 32'h0100_0000, v3(0, 0, 0), v3(32'h101, 0, 0),
                  v3(32'h101, 0, 0), v3(32'hFFFF_FEFF, 0, 0), 1'b0);
      tbl[7] = mk({256'b0, 32'h7FFF_FFFF}, 32'h0100_0000, v3(0, 0, 0), v3(32'h7FFF_FFFF, 0, 0),
                  v3(32'h7FFF_FFFF, 0, 0), v3(32'h8000_0001, 0, 0), 1'b0);
      tbl[8] = mk(diag(32'h0100_0000), 32'h0100_0000, v3(0, 0, 0), v3(32'h8000_0000, 0, 0),
                  v3(32'h8000_0000, 0, 0), v3(32'h7FFF_FFFF, 0, 0), 1'b0);
      tbl[9] = mk({9{32'h0100_0000}}, 32'h0100_0000, v3(0, 0, 0),
                  v3(32'h0100_0000, 32'h0200_0000, 32'h0300_0000), v3(32'h0600_0000, 32'h0600_0000, 32'h0600_0000),
                  v3(32'hFA00_0000, 32'hFA00_0000, 32'hFA00_0000), 1'b0);

      #12;
      chk("reset busy", {31'b0, busy}, 32'd0);
      chk("reset done", {31'b0, done}, 32'd0);
      chk("reset conv", {31'b0, conv}, 32'd0);
      chk("reset x_n", x_n, 32'd0);
      chk("reset dz", dz, 32'd0);
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 10; i++) begin
         run(tbl[i], $sformatf("vec%0d", i), -1, tbl[i]);
         if (i == 5) begin
            repeat (3) @(posedge clk);
            #1;
            chk("hold done", {31'b0, done}, 32'd1);
            chk("hold x_n", x_n, tbl[5].xn[0]);
            chk("hold conv", {31'b0, conv}, 32'd1);
         end
      end

      for (int r = 0; r < 6; r++) begin
         for (int k = 0; k < 9; k++) v.aj[k] = rnd_q();
         v.xv = v3(rnd_q(), rnd_q(), rnd_q());
         v.fv = v3(rnd_q(), rnd_q(), rnd_q());
         v.d  = rnd_q();
         model(v);
         run(v, $sformatf("rnd%0d", r), -1, v);
      end

      run(tbl[0], "en_busy", 5, tbl[3]);

      @(negedge clk);
      drive(tbl[9]);
      en = 1'b1;
      @(posedge clk); #1;
      en = 1'b0;
      scramble();
      repeat (7) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("abort busy", {31'b0, busy}, 32'd0);
      chk("abort done", {31'b0, done}, 32'd0);
      chk("abort conv", {31'b0, conv}, 32'd0);
      chk("abort x_n", x_n, 32'd0);
      chk("abort y_n", y_n, 32'd0);
      chk("abort z_n", z_n, 32'd0);
      chk("abort dx", dx, 32'd0);
      chk("abort dy", dy, 32'd0);
      chk("abort dz", dz, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      repeat (16) @(posedge clk);
      #1;
      chk("idle done", {31'b0, done}, 32'd0);
      chk("idle busy", {31'b0, busy}, 32'd0);
      chk("idle dx", dx, 32'd0);
      run(tbl[3], "post_rst", -1, tbl[3]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
